// File: rtl/ranger_pkg.sv
// Shared types and default timing for the ultrasonic ranger front-end.
// Defaults assume a 100 MHz clock.
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE
    } state_t;

    localparam int DEF_PV_WIDTH            = 9;
    localparam int DEF_TRIG_CYCLES         = 1000;
    localparam int DEF_CYCLES_PER_CM       = 5800;
    localparam int DEF_ECHO_TIMEOUT_CYCLES = 3000000;
    localparam int DEF_MEAS_PERIOD_CYCLES  = 6000000;

    // Bits needed for a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Measurement bus between the ranger (master) and the PID loop (slave).
// The ranger produces distance/valid/timeout/busy and consumes en.
interface ranger_if #(
    parameter int PV_WIDTH = ranger_pkg::DEF_PV_WIDTH
);
    logic                en;
    logic [PV_WIDTH-1:0] distance;
    logic                valid;
    logic                timeout;
    logic                busy;

    modport master (input en, output distance, valid, timeout, busy);
    modport slave  (output en, input distance, valid, timeout, busy);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Resets to 0 so a floating sensor pin looks idle after reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: sequential state uses non-blocking (<=) so both flops sample the pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo pulse timing, cm conversion.
// valid strobes once per finished measurement and drives the PID clk_en.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int PV_WIDTH            = DEF_PV_WIDTH,
    parameter int TRIG_CYCLES         = DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_CM       = DEF_CYCLES_PER_CM,
    parameter int ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
    parameter int MEAS_PERIOD_CYCLES  = DEF_MEAS_PERIOD_CYCLES
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     echo,
    output logic     trig,
    ranger_if.master bus
);
    localparam int TRIG_W = cnt_width(TRIG_CYCLES);
    localparam int CYC_W  = cnt_width(CYCLES_PER_CM);
    localparam int TO_W   = cnt_width(ECHO_TIMEOUT_CYCLES);
    localparam int PER_W  = cnt_width(MEAS_PERIOD_CYCLES);

    localparam logic [PV_WIDTH-1:0] DIST_MAX  = '1;
    localparam logic [TRIG_W-1:0]   TRIG_LAST = TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [CYC_W-1:0]    CYC_LAST  = CYC_W'(CYCLES_PER_CM - 1);
    localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(ECHO_TIMEOUT_CYCLES - 1);
    localparam logic [PER_W-1:0]    PER_LAST  = PER_W'(MEAS_PERIOD_CYCLES - 1);

    logic                echo_s;
    logic [PER_W-1:0]    period_cnt;
    logic                start_tick;

    state_t              state_q, state_d;
    logic [TRIG_W-1:0]   trig_cnt_q, trig_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
    logic [PV_WIDTH-1:0] dist_cnt_q, dist_cnt_d;

    logic [CYC_W-1:0]    cyc_base, cyc_inc;
    logic [PV_WIDTH-1:0] dist_base, dist_inc;
    logic                to_last;
    logic                result_load, result_tmo;

    logic                trig_q, valid_q, timeout_q, busy_q;
    logic [PV_WIDTH-1:0] distance_q;

    sync_2ff u_echo_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (echo),
        .q       (echo_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 period_cnt <= '0;
        else if (!bus.en)             period_cnt <= '0;
        else if (period_cnt == PER_LAST) period_cnt <= '0;
        else                          period_cnt <= period_cnt + 1'b1;
    end

    assign start_tick = bus.en && (period_cnt == '0);
    assign to_last    = (to_cnt_q == TO_LAST);

    // One echo-high clock: the first counted cycle starts from a clean (0,0) pair.
    always_comb begin
        cyc_base  = (state_q == WAIT_ECHO) ? '0 : cyc_cnt_q;
        dist_base = (state_q == WAIT_ECHO) ? '0 : dist_cnt_q;
        if (cyc_base == CYC_LAST) begin
            cyc_inc  = '0;
            dist_inc = (dist_base == DIST_MAX) ? DIST_MAX : dist_base + 1'b1;
        end else begin
            cyc_inc  = cyc_base + 1'b1;
            dist_inc = dist_base;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        trig_cnt_d  = trig_cnt_q;
        to_cnt_d    = to_cnt_q;
        cyc_cnt_d   = cyc_cnt_q;
        dist_cnt_d  = dist_cnt_q;
        result_load = 1'b0;
        result_tmo  = 1'b0;

        if (!bus.en) begin
            state_d    = IDLE;
            trig_cnt_d = '0;
            to_cnt_d   = '0;
            cyc_cnt_d  = '0;
            dist_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A tick seen while echo is still high means the sensor is busy: skip it.
                    if (start_tick && !echo_s) begin
                        state_d    = TRIG;
                        trig_cnt_d = '0;
                    end
                end
                TRIG: begin
                    if (trig_cnt_q == TRIG_LAST) begin
                        state_d    = WAIT_ECHO;
                        trig_cnt_d = '0;
                        to_cnt_d   = '0;
                    end else begin
                        trig_cnt_d = trig_cnt_q + 1'b1;
                    end
                end
                WAIT_ECHO: begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (echo_s) begin
                        state_d    = MEASURE;
                        cyc_cnt_d  = cyc_inc;
                        dist_cnt_d = dist_inc;
                    end else if (to_last) begin
                        state_d     = DONE;
                        result_load = 1'b1;
                        result_tmo  = 1'b1;
                    end
                end
                MEASURE: begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    if (!echo_s) begin
                        state_d     = DONE;
                        result_load = 1'b1;
                    end else if (to_last) begin
                        state_d     = DONE;
                        result_load = 1'b1;
                        result_tmo  = 1'b1;
                    end else begin
                        cyc_cnt_d  = cyc_inc;
                        dist_cnt_d = dist_inc;
                    end
                end
                DONE: begin
                    state_d    = IDLE;
                    to_cnt_d   = '0;
                    cyc_cnt_d  = '0;
                    dist_cnt_d = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            trig_cnt_q <= '0;
            to_cnt_q   <= '0;
            cyc_cnt_q  <= '0;
            dist_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            trig_cnt_q <= trig_cnt_d;
            to_cnt_q   <= to_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
            dist_cnt_q <= dist_cnt_d;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            distance_q <= '0;
        end else begin
            trig_q  <= (state_d == TRIG);
            busy_q  <= (state_d != IDLE);
            valid_q <= result_load;
            if (result_load) begin
                distance_q <= result_tmo ? DIST_MAX : dist_cnt_q;
                timeout_q  <= result_tmo;
            end
        end
    end

    assign trig         = trig_q;
    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.timeout  = timeout_q;
    assign bus.distance = distance_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with small timing parameters.
// Expected distances, latencies and periods are hand-computed constants.
module tb_ultrasonic_ranger;

    localparam int PV    = 4;
    localparam int TRIGC = 3;
    localparam int CPC   = 4;
    localparam int TO    = 100;
    localparam int PER   = 200;

    typedef enum {ECHO_PULSE, ECHO_NONE, ECHO_STUCK} echo_mode_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic echo    = 1'b0;
    logic trig;

    ranger_if #(.PV_WIDTH(PV)) bus ();

    ultrasonic_ranger #(
        .PV_WIDTH            (PV),
        .TRIG_CYCLES         (TRIGC),
        .CYCLES_PER_CM       (CPC),
        .ECHO_TIMEOUT_CYCLES (TO),
        .MEAS_PERIOD_CYCLES  (PER)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .echo    (echo),
        .trig    (trig),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int edge_cnt  = 0;
    int n_valid   = 0;
    int n_checks  = 0;
    int n_pass    = 0;
    int last_rise = 0;
    int wait_edge = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(negedge clk) if (bus.valid === 1'b1) n_valid <= n_valid + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Waits for a trigger pulse, checks its width and leaves wait_edge at WAIT_ECHO entry.
    task automatic wait_trig_cycle(input string tag);
        int k;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (trig !== 1'b1 && k < 300);
        check({tag, "_trig_rise"}, trig, 1);
        last_rise = edge_cnt;
        k = 1;
        do begin
            @(posedge clk); #1;
            if (trig === 1'b1) k++;
        end while (trig === 1'b1 && k < 20);
        check({tag, "_trig_width"}, k, TRIGC);
        wait_edge = edge_cnt;
    endtask

    task automatic measure(input string tag, input echo_mode_t mode, input int n_high,
                           input int exp_dist, input int exp_tmo);
        int ref_edge;
        int exp_lat;
        int v0;
        v0 = n_valid;
        wait_trig_cycle(tag);
        ref_edge = wait_edge;
        exp_lat  = TO;
        if (mode != ECHO_NONE) begin
            @(negedge clk);
            echo = 1'b1;
            if (mode == ECHO_PULSE) begin
                repeat (n_high) @(negedge clk);
                echo     = 1'b0;
                ref_edge = edge_cnt;
                exp_lat  = 3;
            end
        end
        do begin
            @(posedge clk); #1;
        end while (bus.valid !== 1'b1 && edge_cnt - ref_edge < 200);
        check({tag, "_latency"}, edge_cnt - ref_edge, exp_lat);
        check({tag, "_distance"}, bus.distance, exp_dist);
        check({tag, "_timeout"}, bus.timeout, exp_tmo);
        @(posedge clk); #1;
        check({tag, "_valid_1cyc"}, bus.valid, 0);
        check({tag, "_valid_count"}, n_valid - v0, 1);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int en_edge;
        int first_rise;
        int hits;
        int v0;

        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_trig", trig, 0);
        check("rst_distance", bus.distance, 0);
        check("rst_valid", bus.valid, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_busy", bus.busy, 0);

        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_trig", trig, 0);
        check("idle_busy", bus.busy, 0);

        bus.en  = 1'b1;
        en_edge = edge_cnt;
        measure("m42", ECHO_PULSE, 42, 10, 0);
        check("first_trig_edge", last_rise - en_edge, 1);
        first_rise = last_rise;

        measure("m3", ECHO_PULSE, 3, 0, 0);
        check("trig_period", last_rise - first_rise, PER);
        measure("m4", ECHO_PULSE, 4, 1, 0);
        measure("none", ECHO_NONE, 0, 15, 1);
        measure("m80", ECHO_PULSE, 80, 15, 0);
        measure("stuck", ECHO_STUCK, 0, 15, 1);

        // Echo still high across the next start tick: no trigger, no strobe.
        v0   = n_valid;
        hits = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (trig === 1'b1) hits++;
        end
        check("stuck_no_trig", hits, 0);
        check("stuck_no_valid", n_valid - v0, 0);
        check("stuck_idle", bus.busy, 0);
        @(negedge clk);
        echo = 1'b0;
        measure("m8", ECHO_PULSE, 8, 2, 0);

        // en dropped in MEASURE.
        wait_trig_cycle("endrop");
        @(negedge clk);
        echo = 1'b1;
        repeat (10) @(negedge clk);
        check("endrop_busy_before", bus.busy, 1);
        v0     = n_valid;
        bus.en = 1'b0;
        @(posedge clk); #1;
        check("endrop_trig", trig, 0);
        check("endrop_busy", bus.busy, 0);
        @(negedge clk);
        echo = 1'b0;
        repeat (20) @(negedge clk);
        check("endrop_no_valid", n_valid - v0, 0);
        check("endrop_distance_held", bus.distance, 2);
        check("endrop_timeout_held", bus.timeout, 0);

        // Asynchronous reset in MEASURE.
        bus.en = 1'b1;
        wait_trig_cycle("rst_mid");
        @(negedge clk);
        echo = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_busy_before", bus.busy, 1);
        v0      = n_valid;
        reset_n = 1'b0;
        #1;
        check("rst_mid_trig", trig, 0);
        check("rst_mid_distance", bus.distance, 0);
        check("rst_mid_valid", bus.valid, 0);
        check("rst_mid_timeout", bus.timeout, 0);
        check("rst_mid_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        bus.en  = 1'b0;
        echo    = 1'b0;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_mid_no_valid", n_valid - v0, 0);
        check("rst_mid_idle", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
